// File: rtl/trap_arbiter_if.sv
//==============================================================================
// Module   : trap_arbiter_if
// Purpose  : Sequencer-side bundle for trap_arbiter: the available/busy handshake,
//            the request lines and the decision result.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface trap_arbiter_if #(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
  logic               available;
  logic               fault;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic               sw_int;
  logic [1:0]         op;
  logic [IDX_W-1:0]   cause;
  logic               busy;
  logic [NUM_IRQ-1:0] irq_claimed;

  // Sequencer and peripheral side: drives the requests and the handshake, consumes the decision.
  modport master (
    output available, fault, irq, irq_en, sw_int,
    input  op, cause, busy, irq_claimed
  );

  // Arbiter side.
  modport slave (
    input  available, fault, irq, irq_en, sw_int,
    output op, cause, busy, irq_claimed
  );
endinterface

`default_nettype wire

// File: rtl/trap_arbiter.sv
//==============================================================================
// Module   : trap_arbiter
// Purpose  : Fixed-priority arbiter between fault, external IRQs and software
//            interrupt. Edge lines are latched, level lines are used live, and
//            each taken IRQ produces a one-cycle claim pulse.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module trap_arbiter #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter int                 IDX_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  trap_arbiter_if.slave bus
);

  localparam logic [1:0] OP_TRAP   = 2'b00;
  localparam logic [1:0] OP_EXT    = 2'b01;
  localparam logic [1:0] OP_SW     = 2'b10;
  localparam logic [1:0] OP_NORMAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [1:0]         op_q;
  logic [IDX_W-1:0]   cause_q;
  logic               busy_q;
  logic [NUM_IRQ-1:0] claim_q;

  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] eligible;
  logic [IDX_W-1:0]   hit_idx_d;
  logic [1:0]         op_d;
  logic [IDX_W-1:0]   cause_d;
  logic [NUM_IRQ-1:0] claim_d;

  assign req      = (pend_q & EDGE_MASK) | (bus.irq & ~EDGE_MASK);
  assign eligible = req & bus.irq_en;

  // A new rising edge in the same cycle as the claim pulse keeps the bit set.
  assign pend_d = ((pend_q & ~claim_q) | (bus.irq & ~irq_prev_q)) & EDGE_MASK;

  always_comb begin
    hit_idx_d = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        hit_idx_d = IDX_W'(i);
      end
    end
  end

  always_comb begin
    op_d    = OP_NORMAL;
    cause_d = '0;
    claim_d = '0;
    if (bus.fault) begin
      op_d = OP_TRAP;
    end else if (|eligible) begin
      op_d    = OP_EXT;
      cause_d = hit_idx_d;
      claim_d = NUM_IRQ'(1) << hit_idx_d;
    end else if (bus.sw_int) begin
      op_d = OP_SW;
    end
  end

  always_ff @(posedge clk) begin
    // Edge history runs through reset so a line held high creates no edge on release.
    irq_prev_q <= bus.irq;
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      op_q    <= OP_NORMAL;
      cause_q <= '0;
      busy_q  <= 1'b0;
      claim_q <= '0;
    end else begin
      pend_q  <= pend_d;
      claim_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.available) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          op_q    <= op_d;
          cause_q <= cause_d;
          claim_q <= claim_d;
        end
        DONE: begin
          if (!bus.available) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op          = op_q;
  assign bus.cause       = cause_q;
  assign bus.busy        = busy_q;
  assign bus.irq_claimed = claim_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_arbiter.sv
//==============================================================================
// Module   : tb_trap_arbiter
// Purpose  : Directed self-checking bench for trap_arbiter (lines 0..2 edge, line 3 level).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_trap_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  trap_arbiter_if #(.NUM_IRQ(4), .IDX_W(2)) bus ();

  trap_arbiter #(
    .NUM_IRQ  (4),
    .EDGE_MASK(4'b0111),
    .IDX_W    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq(input int line);
    bus.irq[line] = 1'b1;
    tick();
    bus.irq[line] = 1'b0;
    tick();
  endtask

  // Full handshake: busy for one cycle, then the decision with its claim pulse.
  task automatic run_decision(input string tag, input logic [1:0] eop,
                              input logic [1:0] ecause, input logic [3:0] eclaim);
    bus.available = 1'b1;
    tick();
    check_eq({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
    tick();
    check_eq({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_op"}, 32'(bus.op), 32'(eop));
    check_eq({tag, "_cause"}, 32'(bus.cause), 32'(ecause));
    check_eq({tag, "_claim"}, 32'(bus.irq_claimed), 32'(eclaim));
    bus.available = 1'b0;
    tick();
    check_eq({tag, "_claim_off"}, 32'(bus.irq_claimed), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int claim_cnt;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.available = 1'b0;
    bus.fault     = 1'b0;
    bus.irq       = 4'b0001;
    bus.irq_en    = 4'b1111;
    bus.sw_int    = 1'b0;

    // Line 0 held high through reset must not become pending.
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_op", 32'(bus.op), 32'd3);
    check_eq("rst_cause", 32'(bus.cause), 32'd0);
    check_eq("rst_claim", 32'(bus.irq_claimed), 32'd0);
    run_decision("rst_nopend", 2'b11, 2'd0, 4'b0000);
    bus.irq = 4'b0000;
    tick();

    pulse_irq(2);
    pulse_irq(1);
    run_decision("edge_first", 2'b01, 2'd1, 4'b0010);
    run_decision("edge_second", 2'b01, 2'd2, 4'b0100);
    run_decision("edge_drained", 2'b11, 2'd0, 4'b0000);

    // Fault beats a pending IRQ, which then survives to the next decision.
    pulse_irq(0);
    bus.fault  = 1'b1;
    bus.sw_int = 1'b1;
    run_decision("fault_win", 2'b00, 2'd0, 4'b0000);
    bus.fault = 1'b0;
    run_decision("fault_kept", 2'b01, 2'd0, 4'b0001);
    run_decision("sw_only", 2'b10, 2'd0, 4'b0000);

    bus.irq    = 4'b1000;
    bus.irq_en = 4'b0111;
    run_decision("lvl_masked", 2'b10, 2'd0, 4'b0000);
    bus.irq_en = 4'b1111;
    run_decision("lvl_taken", 2'b01, 2'd3, 4'b1000);
    bus.irq    = 4'b0000;
    bus.sw_int = 1'b0;
    tick();

    // Long available: one decision only, even with a new edge arriving in DONE.
    pulse_irq(1);
    busy_cnt      = 0;
    claim_cnt     = 0;
    bus.available = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) bus.irq[2] = 1'b1;
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.irq_claimed != 4'b0000) claim_cnt++;
    end
    bus.irq = 4'b0000;
    check_eq("hold_busy_cnt", 32'(busy_cnt), 32'd1);
    check_eq("hold_claim_cnt", 32'(claim_cnt), 32'd1);
    check_eq("hold_op", 32'(bus.op), 32'd1);
    check_eq("hold_cause", 32'(bus.cause), 32'd1);
    bus.available = 1'b0;
    tick();
    run_decision("hold_next", 2'b01, 2'd2, 4'b0100);

    // Reset in the BUSY cycle clears everything, including pending bits.
    pulse_irq(0);
    bus.available = 1'b1;
    tick();
    check_eq("rbusy_busy_hi", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rbusy_busy", 32'(bus.busy), 32'd0);
    check_eq("rbusy_op", 32'(bus.op), 32'd3);
    check_eq("rbusy_claim", 32'(bus.irq_claimed), 32'd0);
    reset         = 1'b0;
    bus.available = 1'b0;
    tick();
    check_eq("rbusy_idle", 32'(bus.busy), 32'd0);
    run_decision("rbusy_nopend", 2'b11, 2'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
